// File: rtl/signed_div_16by8_pkg.sv
// Shared definitions for the 16-by-8 signed sequential divider: default widths,
// FSM state encoding and the quotient pattern reported on a divide by zero.
package signed_div_16by8_pkg;

    localparam int DIVIDEND_W_DEF = 16;
    localparam int DIVISOR_W_DEF  = 8;

    // Quotient returned when the divisor is zero (all ones at the default width).
    localparam logic [DIVIDEND_W_DEF-1:0] DBZ_QUOTIENT_DEF = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/signed_div_16by8_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the partial
// remainder left, bring in the next dividend bit, trial-subtract the divisor.
module signed_div_16by8_step
    import signed_div_16by8_pkg::*;
#(
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] dvs_i,
    output logic [DIVISOR_W:0]   rem_o,
    output logic                 q_o
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] trial;

    // The bit shifted out of the top means the true value exceeds any divisor,
    // so the subtraction must succeed regardless of the local borrow.
    always_comb begin
        shifted = {rem_i[DIVISOR_W-1:0], bit_i};
        trial   = {1'b0, shifted} - {2'b00, dvs_i};
        q_o     = rem_i[DIVISOR_W] | ~trial[DIVISOR_W+1];
        rem_o   = q_o ? trial[DIVISOR_W:0] : shifted;
    end

endmodule

// File: rtl/signed_div_16by8.sv
// Sequential signed divider (sign-magnitude restoring, one quotient bit per
// clock) with a start/busy/done handshake. Results hold until the next job.
module signed_div_16by8
    import signed_div_16by8_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int                     CNT_W    = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0]  MOST_NEG = {1'b1, {(DIVIDEND_W-1){1'b0}}};
    localparam logic [DIVISOR_W-1:0]   DVS_ONE  = DIVISOR_W'(1);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;          // dividend magnitude, shifts into quotient magnitude
    logic [DIVISOR_W:0]    rem_q, rem_d;          // partial remainder
    logic [DIVISOR_W-1:0]  dvs_mag_q, dvs_mag_d;
    logic                  sign_a_q, sign_a_d;
    logic                  sign_b_q, sign_b_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q;
    logic                  is_dbz;
    logic                  is_ovf;

    signed_div_16by8_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[DIVIDEND_W-1]),
        .dvs_i (dvs_mag_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Special-case detection on the captured magnitudes and signs.
    assign is_dbz = (dvs_mag_q == '0);
    assign is_ovf = sign_a_q & sign_b_q & (dvs_mag_q == DVS_ONE) & (dvd_q == MOST_NEG);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values; everything holds unless the state acts on it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dvs_mag_d   = dvs_mag_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_DIV;
                    cnt_d     = '0;
                    rem_d     = '0;
                    dvd_d     = dividend[DIVIDEND_W-1] ? -dividend : dividend;
                    dvs_mag_d = divisor[DIVISOR_W-1]   ? -divisor  : divisor;
                    sign_a_d  = dividend[DIVIDEND_W-1];
                    sign_b_d  = divisor[DIVISOR_W-1];
                    dbz_d     = 1'b0;
                    ovf_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_DIV: begin
                // Dividend bits leave at the top while quotient bits enter at the bottom.
                dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (is_dbz) begin
                    quotient_d  = '1;
                    remainder_d = '0;
                    dbz_d       = 1'b1;
                end else if (is_ovf) begin
                    quotient_d  = MOST_NEG;
                    remainder_d = '0;
                    ovf_d       = 1'b1;
                end else begin
                    quotient_d  = (sign_a_q ^ sign_b_q) ? -dvd_q : dvd_q;
                    remainder_d = sign_a_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
                end
            end
            ST_DONE: begin
                // done_q rises on the same edge that drops busy and returns to IDLE.
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dvs_mag_q   <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dvs_mag_q   <= dvs_mag_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_div_16by8.sv
// Self-checking bench for signed_div_16by8: directed table, handshake corner
// cases, mid-job reset and randomized jobs against an integer reference model.
module tb_signed_div_16by8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_vec  = 0;
    int n_miss = 0;

    signed_div_16by8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer division (truncates toward zero, remainder
    // follows the dividend) plus the two special cases.
    function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                    output logic [15:0] q, output logic [7:0] r,
                                    output logic dz, output logic ov);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            q  = 16'hFFFF;
            r  = 8'h00;
        end else if (sa == -32768 && sb == -1) begin
            ov = 1'b1;
            q  = 16'h8000;
            r  = 8'h00;
        end else begin
            q = 16'(sa / sb);
            r = 8'(sa % sb);
        end
    endfunction

    // Runs one job; optionally re-pulses start with junk operands mid-job.
    // Checks handshake timing and result hold; returns the sampled results.
    task automatic run_job(input logic [15:0] a, input logic [7:0] b, input string tag,
                           input int glitch_at,
                           output logic [15:0] q_o, output logic [7:0] r_o,
                           output logic dz_o, output logic ov_o);
        int lat;
        int bad_busy;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        lat      = 0;
        bad_busy = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) bad_busy++;
            if (glitch_at > 0 && lat == glitch_at - 1) begin
                start    = 1'b1;
                dividend = 16'hEC78;
                divisor  = 8'h03;
            end else if (glitch_at > 0 && lat == glitch_at) begin
                start = 1'b0;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd18);
        chk({tag, " busy_gap"}, 32'(bad_busy), 32'd0);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        q_o  = quotient;
        r_o  = remainder;
        dz_o = div_by_zero;
        ov_o = overflow;
        $display("job %s: a=%h b=%h -> q=%h r=%h dz=%b ov=%b lat=%0d",
                 tag, a, b, q_o, r_o, dz_o, ov_o, lat);
        @(posedge clk);
        #1;
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " q_hold"}, 32'(quotient), 32'(q_o));
    endtask

    initial begin
        logic [15:0] q, eq, ra;
        logic [7:0]  r, er, rb;
        logic        dz, ov, edz, eov;
        int          cyc, first_done, second_done, done_cnt;

        tbl[0] = '{16'd100,  8'd7,   16'h000E, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{16'hFF9C, 8'd7,   16'hFFF2, 8'hFE, 1'b0, 1'b0};
        tbl[2] = '{16'd100,  8'hF9,  16'hFFF2, 8'h02, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 8'h80,  16'h0100, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{16'h7FFF, 8'h80,  16'hFF01, 8'h7F, 1'b0, 1'b0};
        tbl[5] = '{16'h8000, 8'hFF,  16'h8000, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{16'd1234, 8'h00,  16'hFFFF, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{16'h0000, 8'd5,   16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[8] = '{16'hFFFF, 8'hFF,  16'h0001, 8'h00, 1'b0, 1'b0};
        tbl[9] = '{16'hFFF9, 8'd2,   16'hFFFD, 8'hFF, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset outputs", {quotient, remainder, 6'b0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i].a, tbl[i].b, $sformatf("tbl%0d", i), 0, q, r, dz, ov);
            chk($sformatf("tbl%0d quotient", i), 32'(q), 32'(tbl[i].q));
            chk($sformatf("tbl%0d remainder", i), 32'(r), 32'(tbl[i].r));
            chk($sformatf("tbl%0d div_by_zero", i), 32'(dz), 32'(tbl[i].dz));
            chk($sformatf("tbl%0d overflow", i), 32'(ov), 32'(tbl[i].ov));
        end

        // start re-pulsed at cycle 5 with other operands is ignored
        run_job(16'd100, 8'd7, "glitch", 5, q, r, dz, ov);
        chk("glitch quotient", 32'(q), 32'h000E);
        chk("glitch remainder", 32'(r), 32'h02);

        // start held high: back-to-back jobs every 19 clocks
        @(negedge clk);
        start       = 1'b1;
        dividend    = 16'd100;
        divisor     = 8'd7;
        first_done  = -1;
        second_done = -1;
        cyc         = 0;
        @(posedge clk);
        #1;
        while (second_done < 0 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) begin
                if (first_done < 0) begin
                    first_done = cyc;
                    chk("b2b first quotient", 32'(quotient), 32'h000E);
                    dividend = 16'hFF9C;
                end else begin
                    second_done = cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        $display("job b2b: first done at %0d, second at %0d, q=%h r=%h",
                 first_done, second_done, quotient, remainder);
        chk("b2b first latency", 32'(first_done), 32'd18);
        chk("b2b period", 32'(second_done - first_done), 32'd19);
        chk("b2b second quotient", 32'(quotient), 32'hFFF2);
        chk("b2b second remainder", 32'(remainder), 32'hFE);
        @(posedge clk);
        #1;
        chk("b2b no third job", 32'(busy), 32'd0);

        // Reset in the middle of a job
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1234;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst quotient", 32'(quotient), 32'd0);
        chk("midrst remainder", 32'(remainder), 32'd0);
        chk("midrst flags", {30'b0, div_by_zero, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        $display("job midrst: aborted, activity cycles after release=%0d", done_cnt);
        chk("midrst no done", 32'(done_cnt), 32'd0);
        run_job(16'd100, 8'd7, "after_rst", 0, q, r, dz, ov);
        chk("after_rst quotient", 32'(q), 32'h000E);
        chk("after_rst remainder", 32'(r), 32'h02);

        // Randomized jobs against the reference model
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: begin ra = 16'h8000; rb = 8'hFF; end
                2: ra = 16'h8000;
                3: rb = 8'h80;
                4: rb = 8'hFF;
                default: ;
            endcase
            ref_div(ra, rb, eq, er, edz, eov);
            run_job(ra, rb, $sformatf("rnd%0d", i), 0, q, r, dz, ov);
            chk($sformatf("rnd%0d result", i), {q, r, 6'b0, dz, ov}, {eq, er, 6'b0, edz, eov});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
